alu_sequencer: RTL and testbench

Sequential front end for the combinational 4-bit ALU (A, B, OP → Result). Accepts operation requests over a valid/ready handshake and buffers them in an in-order FIFO. Issues one request per cycle to the ALU's input pins, captures the ALU's Result, and returns it over a valid/ready response channel. A chain bit lets a request use the previous issued result as operand A, so test protocols can express multi-step computations without a host round-trip.

---
 rtl/alu_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - in-order request FIFO and response register in front of a 4-bit combinational ALU
module alu_sequencer #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_a,
    input  logic [3:0]    req_b,
    input  logic [2:0]    req_op,
    input  logic          req_chain,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [3:0]    alu_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [3:0]    rsp_result,
    output logic          rsp_err,
    output logic [CW-1:0] count
);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       chain;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      acc_q, acc_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [3:0]      rsp_result_q, rsp_result_d;
    logic            rsp_err_q, rsp_err_d;

    logic            full, empty, push, issue, illegal;
    entry_t          head, push_entry;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign push       = req_valid && !full;
    // req_ready depends only on registered occupancy, never on rsp_ready.
    assign issue      = !empty && (!rsp_valid_q || rsp_ready);
    assign head       = mem_q[rd_ptr_q];
    assign illegal    = (head.op >= 3'd5);
    assign push_entry = '{a: req_a, b: req_b, op: req_op, chain: req_chain};

    assign req_ready  = !full;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign count      = count_q;

    always_comb begin
        alu_a  = 4'd0;
        alu_b  = 4'd0;
        alu_op = 3'd0;
        if (!empty) begin
            alu_a  = head.chain ? acc_q : head.a;
            alu_b  = head.b;
            alu_op = head.op;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        acc_d        = acc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // An issue overwrites any response being drained in the same cycle.
        if (issue) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_err_d    = illegal;
            acc_d        = illegal ? 4'd0 : alu_result;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            acc_q        <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 4'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer
module tb_alu_sequencer;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_chain;
    logic [3:0]    req_a, req_b;
    logic [2:0]    req_op;
    logic [3:0]    alu_a, alu_b, alu_result;
    logic [2:0]    alu_op;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [3:0]    rsp_result;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_chain(req_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .count(count)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational ALU the sequencer drives.
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            default: alu_result = 4'd0;
        endcase
    end

    // Reference: each accepted request, in order, yields {err, result}.
    function automatic logic [4:0] model(input int a, input int b, input int op);
        int r;
        logic e;
        e = 1'b0;
        case (op)
            0:       r = (a + b) % 16;
            1:       r = (a - b + 16) % 16;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, 4'(r)};
    endfunction

    int         m_acc = 0;
    int         cyc = 0;
    logic [4:0] pend_q[$];
    logic [3:0] obs_res[$];
    logic       obs_err[$];
    logic [3:0] exp_res[$];
    logic       exp_err[$];
    int         obs_cyc[$];

    always @(negedge clk) begin
        logic [4:0] e;
        cyc++;
        if (reset) begin
            m_acc = 0;
            pend_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                e = (pend_q.size() > 0) ? pend_q.pop_front() : 5'bx;
                obs_res.push_back(rsp_result);
                obs_err.push_back(rsp_err);
                exp_res.push_back(e[3:0]);
                exp_err.push_back(e[4]);
                obs_cyc.push_back(cyc);
            end
            if (req_valid && req_ready) begin
                e = model(req_chain ? m_acc : int'(req_a), int'(req_b), int'(req_op));
                m_acc = int'(e[3:0]);
                pend_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_res.delete(); obs_err.delete(); exp_res.delete(); exp_err.delete(); obs_cyc.delete();
    endtask

    task automatic set_req(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic ch);
        req_a = a; req_b = b; req_op = op; req_chain = ch;
    endtask

    task automatic rand_req();
        set_req(4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
    endtask

    task automatic drain(output bit ok);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (count == 0 && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        req_valid = 1'b0; rsp_ready = 1'b0; set_req(0, 0, 0, 0);
        reset = 1'b1; step(); step(); reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0d expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0d expected 0", rsp_valid); end
        checks++; if (count !== 0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if ({alu_a, alu_b, alu_op} !== 11'd0) begin errors++; $display("FAIL rst_alu: got %h/%h/%h expected 0/0/0", alu_a, alu_b, alu_op); end
        checks++; if ({rsp_result, rsp_err} !== 5'd0) begin errors++; $display("FAIL rst_rsp: got %h/%0d expected 0/0", rsp_result, rsp_err); end
        // Busy: one response held, three queued.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; rand_req(); step();
        end
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 3 || rsp_valid !== 1'b1) begin errors++; $display("FAIL busy_fill: got count %0d valid %0d expected 3 1", count, rsp_valid); end
        @(posedge clk); #1;
        reset = 1'b1; step(); reset = 1'b0;
        @(negedge clk);
        checks++; if (count !== 0 || rsp_valid !== 1'b0 || rsp_result !== 4'd0 || rsp_err !== 1'b0 || req_ready !== 1'b1)
            begin errors++; $display("FAIL busy_reset: got count %0d valid %0d res %0d err %0d ready %0d expected 0 0 0 0 1", count, rsp_valid, rsp_result, rsp_err, req_ready); end
        clear_obs();
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b1; set_req(4'hA, 4'd3, 3'd0, 1'b1); step();
        req_valid = 1'b0;
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_drain: got timeout expected drained"); end
        checks++; if (obs_res.size() != 1 || obs_res[0] !== 4'd3 || obs_err[0] !== 1'b0)
            begin errors++; $display("FAIL chain_after_reset: got n=%0d res %0d expected n=1 res 3", obs_res.size(), obs_res.size() ? obs_res[0] : 4'd0); end
    endtask

    task automatic test_single_add();
        bit ok;
        clear_obs();
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b1; set_req(4'd3, 4'd4, 3'd0, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (alu_a !== 4'd3 || alu_b !== 4'd4 || alu_op !== 3'd0 || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL add_t1: got a %0d b %0d op %0d valid %0d expected 3 4 0 0", alu_a, alu_b, alu_op, rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 4'd7 || rsp_err !== 1'b0)
            begin errors++; $display("FAIL add_t2: got valid %0d res %0d err %0d expected 1 7 0", rsp_valid, rsp_result, rsp_err); end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_drain: got timeout expected drained"); end
    endtask

    task automatic test_chain();
        bit ok;
        clear_obs();
        @(posedge clk); #1;
        req_valid = 1'b1; set_req(4'd2, 4'd5, 3'd1, 1'b0); step();
        set_req(4'($urandom), 4'd4, 3'd0, 1'b1); step();
        req_valid = 1'b0;
        drain(ok);
        checks++; if (!ok || obs_res.size() != 2) begin errors++; $display("FAIL chain_count: got %0d expected 2", obs_res.size()); end
        else begin
            checks++; if (obs_res[0] !== 4'd13) begin errors++; $display("FAIL chain_wrap: got %0d expected 13", obs_res[0]); end
            checks++; if (obs_res[1] !== 4'd1) begin errors++; $display("FAIL chain_use: got %0d expected 1", obs_res[1]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok, acc;
        int idx;
        clear_obs();
        @(posedge clk); #1;
        rsp_ready = 1'b0; idx = 0; req_valid = 1'b1; set_req(4'd0, 4'd1, 3'd0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1;
            if (acc) begin idx++; set_req(4'(idx), 4'd1, 3'd0, 1'b0); end
        end
        @(negedge clk);
        checks++; if (idx != 5 || count !== 4 || req_ready !== 1'b0 || rsp_valid !== 1'b1)
            begin errors++; $display("FAIL bp_capacity: got acc %0d count %0d ready %0d expected 5 4 0", idx, count, req_ready); end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && idx < 6; i++) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        req_valid = 1'b0;
        drain(ok);
        checks++; if (!ok || obs_res.size() != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", obs_res.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (obs_res[i] !== 4'(i + 1) || obs_err[i] !== 1'b0)
                    begin errors++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, obs_res[i], i + 1); end
            end
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_cyc[i + 1] - obs_cyc[i] != 1)
                    begin errors++; $display("FAIL bp_rate[%0d]: got gap %0d expected 1", i, obs_cyc[i + 1] - obs_cyc[i]); end
            end
        end
    endtask

    task automatic test_illegal();
        bit ok;
        clear_obs();
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b1; set_req(4'd9, 4'd9, 3'd6, 1'b0); step();
        set_req(4'($urandom), 4'd5, 3'd4, 1'b1); step();
        req_valid = 1'b0;
        drain(ok);
        checks++; if (!ok || obs_res.size() != 2) begin errors++; $display("FAIL ill_count: got %0d expected 2", obs_res.size()); end
        else begin
            checks++; if (obs_res[0] !== 4'd0 || obs_err[0] !== 1'b1) begin errors++; $display("FAIL ill_op: got res %0d err %0d expected 0 1", obs_res[0], obs_err[0]); end
            checks++; if (obs_res[1] !== 4'd5 || obs_err[1] !== 1'b0) begin errors++; $display("FAIL ill_chain: got res %0d err %0d expected 5 0", obs_res[1], obs_err[1]); end
        end
    endtask

    task automatic test_full_stream();
        bit ok, acc;
        int n_acc;
        clear_obs();
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b1; rand_req(); n_acc = 0;
        for (int i = 0; i < 20 && n_acc < DEPTH + 1; i++) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1;
            if (acc) begin n_acc++; rand_req(); end
        end
        @(negedge clk);
        checks++; if (count !== CW'(DEPTH) || req_ready !== 1'b0) begin errors++; $display("FAIL full_fill: got count %0d expected %0d", count, DEPTH); end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); acc = req_ready;
            checks++; if (count !== CW'(DEPTH) && count !== CW'(DEPTH - 1))
                begin errors++; $display("FAIL full_hold[%0d]: got count %0d expected %0d or %0d", i, count, DEPTH - 1, DEPTH); end
            @(posedge clk); #1;
            if (acc) begin n_acc++; rand_req(); end
        end
        req_valid = 1'b0;
        drain(ok);
        checks++; if (!ok || obs_res.size() != n_acc) begin errors++; $display("FAIL full_count: got %0d expected %0d", obs_res.size(), n_acc); end
        for (int i = 0; i < obs_res.size(); i++) begin
            checks++; if (obs_res[i] !== exp_res[i] || obs_err[i] !== exp_err[i])
                begin errors++; $display("FAIL full_data[%0d]: got %0d/%0d expected %0d/%0d", i, obs_res[i], obs_err[i], exp_res[i], exp_err[i]); end
        end
    endtask

    task automatic test_random();
        bit ok, acc;
        int n_acc;
        clear_obs();
        n_acc = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(3) != 0);
            rsp_ready = ($urandom_range(4) > 1);
            rand_req();
            @(negedge clk); acc = req_valid && req_ready;
            checks++; if (count > CW'(DEPTH) || (req_ready !== (count != CW'(DEPTH))))
                begin errors++; $display("FAIL rnd_flags[%0d]: got count %0d ready %0d expected count<=%0d ready=!full", i, count, req_ready, DEPTH); end
            if (acc) n_acc++;
            @(posedge clk); #1;
        end
        drain(ok);
        checks++; if (!ok || obs_res.size() != n_acc) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", obs_res.size(), n_acc); end
        for (int i = 0; i < obs_res.size(); i++) begin
            checks++; if (obs_res[i] !== exp_res[i] || obs_err[i] !== exp_err[i])
                begin errors++; $display("FAIL rnd_data[%0d]: got %0d/%0d expected %0d/%0d", i, obs_res[i], obs_err[i], exp_res[i], exp_err[i]); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; set_req(0, 0, 0, 0);
        test_reset();
        test_single_add();
        test_chain();
        test_backpressure();
        test_illegal();
        test_full_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
